clock_divider_mc: RTL and testbench
===================================

CLOCK_DIVIDER_MC -- requirements
Module: clock_divider_mc

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divider channels, legal range 1..16.
REQ-002 Parameter DIV_W, default 16: width of each channel divisor.
REQ-003 clk_in  input  1  single source clock; all state updates on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 en  input  NUM_CH  per-channel run enable, level-sensitive.
REQ-006 load  input  NUM_CH  per-channel one-cycle strobe that captures a new divisor.
REQ-007 div  input  NUM_CH*DIV_W  divisor bus; channel i occupies bits [i*DIV_W +: DIV_W].
REQ-008 clk_out  output  NUM_CH  divided clocks; each bit is driven directly from a flop.
REQ-009 tick  output  NUM_CH  one-cycle pulse marking the start of each output period.
REQ-010 busy  output  NUM_CH  high while a channel is running or draining.

Function
REQ-011 Each channel holds the following state: a shadow divisor register, an active divisor register, a counter (DIV_W bits), and a state machine.
REQ-012 The channel state machine SHALL use the states IDLE, RUN and DRAIN.
REQ-013 Effective divisor SHALL be max(value, 2); values 0 and 1 are treated as 2.
REQ-014 Output period SHALL be exactly D clk_in cycles, where D is the effective active divisor.
REQ-015 Output SHALL be high for H = D - floor(D/2) cycles and low for floor(D/2) cycles. Even D gives 50% duty; odd D has one extra high cycle.
REQ-016 Counter SHALL count 0..D-1 and wrap to 0; clk_out SHALL be high exactly while counter < H.
REQ-017 load in IDLE: the div slice SHALL be written to both the shadow and active divisor registers on the same edge.
REQ-018 load in RUN or DRAIN: the div slice SHALL be written to the shadow register only. The active register SHALL take the shadow value at the next wrap, so a period is never truncated or stretched.
REQ-019 If several loads occur within one period, the last one before the wrap wins.
REQ-020 IDLE->RUN when en is sampled high: counter=0, clk_out=1 and tick=1 on the first edge after en is sampled high, giving a latency of 1 cycle.
REQ-021 RUN->DRAIN when en is sampled low. The current period SHALL complete unchanged.
REQ-022 DRAIN->IDLE at the wrap point. clk_out SHALL be 0 in IDLE, and no tick SHALL be issued for the aborted next period.
REQ-023 DRAIN->RUN if en is sampled high again before the wrap. Output SHALL continue seamlessly with no phase reset.
REQ-024 tick SHALL be 1 in the same cycle that clk_out rises: on RUN entry and on every wrap while in RUN.
REQ-025 busy SHALL be 1 in RUN and DRAIN, and 0 in IDLE.
REQ-026 Channels SHALL be fully independent; no event on channel i affects channel j.
REQ-027 clk_out SHALL never exhibit a high or low phase shorter than floor(D/2) cycles of either the old or the new divisor, including across divisor change and stop.
REQ-028 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-029 While rstn=0, every channel SHALL be in IDLE with: clk_out=0, tick=0, busy=0, counter=0, shadow=active=2.
REQ-030 Reset assertion mid-period SHALL force the reset values immediately (asynchronously) and discard any pending load.
REQ-031 After rstn deassertion, a channel SHALL remain in IDLE until en is sampled high.

Verification
REQ-032 Divide by 4: load div=4, en=1 -> clk_out pattern 1,1,0,0 repeating; tick every 4th cycle, aligned to each rising edge.
REQ-033 Divide by 5: load div=5, en=1 -> clk_out 1,1,1,0,0; period 5 cycles.
REQ-034 Divisor edge cases: div=0 and div=1 -> each behaves as divide by 2 (pattern 1,0).
REQ-035 Mid-period divisor change: running at div=6, load div=3 at counter=1 -> current period finishes as 1,1,1,0,0,0, then the output becomes 1,1,0 with no glitch.
REQ-036 Drain and re-enable:
- running at div=8, deassert en at counter=2 -> clk_out completes 1,1,0,0,0,0 for that period; busy falls at the wrap; clk_out then stays 0.
- re-asserting en at counter=5 of that draining period -> no gap in the output.
REQ-037 Reset and channel independence:
- assert rstn=0 at counter=3 of a div=10 period -> clk_out=0 and busy=0 immediately.
- during that reset, other channels reset too.
- separately, toggling en or load on channel 0 leaves channel 1 (div=7) unperturbed.

Source files
------------

// File: rtl/clock_divider_mc.sv
// Multi-channel programmable clock divider. Each channel divides clk_in by a
// per-channel divisor with glitch-free divisor changes and period-completing stop.
module clock_divider_mc #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = 16
) (
  input  logic                    clk_in,
  input  logic                    rstn,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*DIV_W-1:0] div,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic [DIV_W-1:0] active_q, active_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;
    logic [DIV_W-1:0] div_raw, div_eff, cnt_inc, high_len;
    logic             wrap;

    // Divisor clamp, high-phase length and end-of-period detect
    always_comb begin
      div_raw  = div[i*DIV_W +: DIV_W];
      div_eff  = (div_raw < DIV_MIN) ? DIV_MIN : div_raw;
      high_len = active_q - (active_q >> 1);
      cnt_inc  = cnt_q + DIV_W'(1);
      wrap     = (cnt_q == active_q - DIV_W'(1));
    end

    // Next-state and next-output logic
    always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      active_d = active_q;
      cnt_d    = cnt_q;
      clk_d    = 1'b0;
      tick_d   = 1'b0;
      busy_d   = 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (load[i]) begin
            shadow_d = div_eff;
            active_d = div_eff;
          end
          if (en[i]) begin
            state_d = ST_RUN;
            clk_d   = 1'b1;
            tick_d  = 1'b1;
            busy_d  = 1'b1;
          end
        end
        ST_RUN, ST_DRAIN: begin
          if (load[i]) shadow_d = div_eff;
          if (wrap) begin
            // Divisor handover only at a period boundary
            active_d = shadow_q;
            cnt_d    = '0;
            if (en[i]) begin
              state_d = ST_RUN;
              clk_d   = 1'b1;
              tick_d  = 1'b1;
              busy_d  = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d   = cnt_inc;
            clk_d   = (cnt_inc < high_len);
            busy_d  = 1'b1;
            state_d = en[i] ? ST_RUN : ST_DRAIN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk_in or negedge rstn) begin
      if (!rstn) begin
        state_q  <= ST_IDLE;
        shadow_q <= DIV_MIN;
        active_q <= DIV_MIN;
        cnt_q    <= '0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        shadow_q <= shadow_d;
        active_q <= active_d;
        cnt_q    <= cnt_d;
        clk_q    <= clk_d;
        tick_q   <= tick_d;
        busy_q   <= busy_d;
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
    assign busy[i]    = busy_q;
  end

endmodule

// File: tb/tb_clock_divider_mc.sv
// Scoreboard bench for clock_divider_mc: a period-as-sample-list reference model
// pushes expected outputs per cycle; a monitor pops and compares after each edge.
module tb_clock_divider_mc;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DIV_W  = 16;

  logic                    clk_in = 1'b0;
  logic                    rstn   = 1'b0;
  logic [NUM_CH-1:0]       en     = '0;
  logic [NUM_CH-1:0]       load   = '0;
  logic [NUM_CH*DIV_W-1:0] div    = '0;
  logic [NUM_CH-1:0]       clk_out, tick, busy;

  clock_divider_mc #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
    .clk_in(clk_in), .rstn(rstn), .en(en), .load(load), .div(div),
    .clk_out(clk_out), .tick(tick), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [NUM_CH-1:0] c;
    logic [NUM_CH-1:0] t;
    logic [NUM_CH-1:0] b;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        m_exp;
  int          n_pass  = 0;
  int          n_total = 0;
  int          m_sh  [NUM_CH];
  int          m_act [NUM_CH];
  bit          m_run [NUM_CH];
  bit          m_rem [NUM_CH][$];
  logic [31:0] h_clk  = '0;
  logic [31:0] h_tick = '0;
  logic [31:0] h_busy = '0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, want);
  endtask

  function automatic int eff(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  // A period is a list of D output samples: ceil(D/2) ones then floor(D/2) zeros
  task automatic start_period(input int c);
    for (int k = 0; k < m_act[c]; k++) m_rem[c].push_back(k < (m_act[c] - m_act[c] / 2));
    void'(m_rem[c].pop_front());
  endtask

  task automatic model_step(input bit rn, input logic [NUM_CH-1:0] e, input logic [NUM_CH-1:0] l,
                            input logic [NUM_CH*DIV_W-1:0] d);
    m_exp = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      int v;
      int nsh;
      v = eff(int'(d[c*DIV_W +: DIV_W]));
      if (!rn) begin
        m_run[c] = 1'b0;
        m_rem[c].delete();
        m_sh[c]  = 2;
        m_act[c] = 2;
      end else if (!m_run[c]) begin
        if (l[c]) begin
          m_sh[c]  = v;
          m_act[c] = v;
        end
        if (e[c]) begin
          m_run[c] = 1'b1;
          start_period(c);
          m_exp.c[c] = 1'b1;
          m_exp.t[c] = 1'b1;
          m_exp.b[c] = 1'b1;
        end
      end else begin
        nsh = l[c] ? v : m_sh[c];
        if (m_rem[c].size() == 0) begin
          m_act[c] = m_sh[c];
          if (e[c]) begin
            start_period(c);
            m_exp.c[c] = 1'b1;
            m_exp.t[c] = 1'b1;
            m_exp.b[c] = 1'b1;
          end else begin
            m_run[c] = 1'b0;
          end
        end else begin
          m_exp.c[c] = m_rem[c].pop_front();
          m_exp.b[c] = 1'b1;
        end
        m_sh[c] = nsh;
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expected response
  task automatic drive(input bit rn, input logic [NUM_CH-1:0] e, input logic [NUM_CH-1:0] l,
                       input logic [NUM_CH*DIV_W-1:0] d);
    @(negedge clk_in);
    rstn = rn;
    en   = e;
    load = l;
    div  = d;
    if (!rn) begin
      #1;
      check("async_reset", 64'({clk_out, tick, busy}), 64'(0));
    end
    model_step(rn, e, l, d);
    sb_q.push_back(m_exp);
  endtask

  // Channel 0 directed, channel 1 free-running, the rest random
  task automatic ch0(input bit e0, input bit l0, input int v0);
    logic [NUM_CH-1:0]       e;
    logic [NUM_CH-1:0]       l;
    logic [NUM_CH*DIV_W-1:0] d;
    for (int c = 0; c < NUM_CH; c++) begin
      e[c] = 1'($urandom_range(0, 1));
      l[c] = ($urandom_range(0, 9) == 0);
      d[c*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 9));
    end
    e[0] = e0;
    l[0] = l0;
    d[DIV_W-1:0] = DIV_W'(v0);
    e[1] = 1'b1;
    l[1] = 1'b0;
    d[2*DIV_W-1:DIV_W] = DIV_W'(7);
    drive(1'b1, e, l, d);
  endtask

  task automatic settle();
    @(posedge clk_in);
    #2;
  endtask

  always @(posedge clk_in) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("scoreboard", 64'({clk_out, tick, busy}), 64'(e));
    end
    h_clk  = {h_clk[30:0], clk_out[0]};
    h_tick = {h_tick[30:0], tick[0]};
    h_busy = {h_busy[30:0], busy[0]};
  end

  initial begin
    logic [NUM_CH-1:0]       re, rl;
    logic [NUM_CH*DIV_W-1:0] rd;
    for (int c = 0; c < NUM_CH; c++) begin
      m_sh[c]  = 2;
      m_act[c] = 2;
      m_run[c] = 1'b0;
    end
    for (int k = 0; k < 3; k++) drive(1'b0, '0, '0, '0);
    settle();
    check("reset_outputs", 64'({clk_out, tick, busy}), 64'(0));

    // Release reset, load channel 1 with 7, everything idle
    rd = '0;
    rd[2*DIV_W-1:DIV_W] = DIV_W'(7);
    drive(1'b1, '0, 4'b0010, rd);
    drive(1'b1, '0, '0, '0);
    drive(1'b1, '0, '0, '0);
    settle();
    check("idle_after_reset", 64'(busy), 64'(0));

    ch0(1'b0, 1'b1, 4);
    for (int k = 0; k < 8; k++) ch0(1'b1, 1'b0, 0);
    settle();
    check("div4_clk", 64'(h_clk[7:0]), 64'(8'b11001100));
    check("div4_tick", 64'(h_tick[7:0]), 64'(8'b10001000));
    for (int k = 0; k < 6; k++) ch0(1'b0, 1'b0, 0);

    ch0(1'b0, 1'b1, 5);
    for (int k = 0; k < 10; k++) ch0(1'b1, 1'b0, 0);
    settle();
    check("div5_clk", 64'(h_clk[9:0]), 64'(10'b1110011100));
    for (int k = 0; k < 6; k++) ch0(1'b0, 1'b0, 0);

    for (int v = 0; v < 2; v++) begin
      ch0(1'b0, 1'b1, v);
      for (int k = 0; k < 4; k++) ch0(1'b1, 1'b0, 0);
      settle();
      check(v == 0 ? "div0_clk" : "div1_clk", 64'(h_clk[3:0]), 64'(4'b1010));
      for (int k = 0; k < 3; k++) ch0(1'b0, 1'b0, 0);
    end

    // Divisor change 6 -> 3 loaded while counter is 1
    ch0(1'b0, 1'b1, 6);
    ch0(1'b1, 1'b0, 0);
    ch0(1'b1, 1'b0, 0);
    ch0(1'b1, 1'b1, 3);
    for (int k = 0; k < 9; k++) ch0(1'b1, 1'b0, 0);
    settle();
    check("midchange_clk", 64'(h_clk[11:0]), 64'(12'b111000110110));
    for (int k = 0; k < 4; k++) ch0(1'b0, 1'b0, 0);

    // Stop at counter 2 of a divide-by-8 period
    ch0(1'b0, 1'b1, 8);
    for (int k = 0; k < 3; k++) ch0(1'b1, 1'b0, 0);
    for (int k = 0; k < 8; k++) ch0(1'b0, 1'b0, 0);
    settle();
    check("drain_clk", 64'(h_clk[10:0]), 64'(11'b11110000000));
    check("drain_busy", 64'(h_busy[10:0]), 64'(11'b11111111000));

    // Re-enable at counter 5 while draining
    for (int k = 0; k < 3; k++) ch0(1'b1, 1'b0, 0);
    for (int k = 0; k < 3; k++) ch0(1'b0, 1'b0, 0);
    for (int k = 0; k < 10; k++) ch0(1'b1, 1'b0, 0);
    settle();
    check("reenable_clk", 64'(h_clk[15:0]), 64'(16'b1111000011110000));
    check("reenable_busy", 64'(h_busy[15:0]), 64'(16'hFFFF));
    for (int k = 0; k < 9; k++) ch0(1'b0, 1'b0, 0);

    // Asynchronous reset at counter 3 of a divide-by-10 period
    ch0(1'b0, 1'b1, 10);
    for (int k = 0; k < 4; k++) ch0(1'b1, 1'b0, 0);
    settle();
    check("pre_reset_busy", 64'(busy[1:0]), 64'(2'b11));
    drive(1'b0, '1, '0, '0);
    drive(1'b0, '1, '0, '0);
    drive(1'b1, '0, '0, '0);

    // Randomized traffic with occasional resets
    re = '0;
    for (int n = 0; n < 2500; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 9) < 2) re[c] = ~re[c];
        rl[c] = ($urandom_range(0, 9) == 0);
        rd[c*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 12));
      end
      drive(($urandom_range(0, 399) != 0), re, rl, rd);
    end

    for (int k = 0; k < 16; k++) drive(1'b1, '0, '0, '0);
    settle();
    check("final_idle", 64'(busy), 64'(0));
    check("scoreboard_drained", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
